// File: rtl/matmul_apb_master_if.sv
// Request/response and APB bus bundle for the matmul APB master stage.
// The master modport is the bridge itself; the slave modport is everything around it.
interface matmul_apb_master_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int STRB_W = BUS_WIDTH / 8;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic                  req_wait_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [BUS_WIDTH-1:0]  req_wdata_i;
    logic [STRB_W-1:0]     req_strb_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [BUS_WIDTH-1:0]  rsp_rdata_o;
    logic [1:0]            rsp_err_o;

    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [BUS_WIDTH-1:0]  pwdata_o;
    logic [STRB_W-1:0]     pstrb_o;
    logic                  pready_i;
    logic                  pslverr_i;
    logic [BUS_WIDTH-1:0]  prdata_i;

    logic                  busy_i;
    logic [7:0]            err_cnt_o;

    modport master (
        input  req_valid_i, req_write_i, req_wait_i, req_addr_i, req_wdata_i, req_strb_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  pready_i, pslverr_i, prdata_i,
        input  busy_i,
        output err_cnt_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_wait_i, req_addr_i, req_wdata_i, req_strb_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output pready_i, pslverr_i, prdata_i,
        output busy_i,
        input  err_cnt_o
    );
endinterface

// File: rtl/matmul_apb_master.sv
// Turns single valid/ready requests into two-phase APB transfers to the matmul
// slave, with optional hold-off on busy, pready timeout and an error counter.
module matmul_apb_master #(
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    matmul_apb_master_if.master  bus
);
    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                state_reg;
    logic                  ready_reg;
    logic                  psel_reg;
    logic                  penable_reg;
    logic                  rsp_valid_reg;
    logic                  write_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [BUS_WIDTH-1:0]  wdata_reg;
    logic [STRB_W-1:0]     strb_reg;
    logic [BUS_WIDTH-1:0]  rdata_reg;
    logic [1:0]            err_reg;
    logic [7:0]            err_cnt_reg;
    logic [CNT_W-1:0]      wait_cnt_reg;

    logic [STRB_W-1:0]     strb_next;
    logic [CNT_W-1:0]      wait_cnt_next;
    logic                  timeout_hit;

    // Reads carry no byte enables on the bus.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
            assign strb_next[gi] = bus.req_write_i & bus.req_strb_i[gi];
        end
    endgenerate

    assign wait_cnt_next = wait_cnt_reg + 1'b1;
    assign timeout_hit   = (TIMEOUT_CYC != 0) && (wait_cnt_next == TIMEOUT_VAL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            strb_reg      <= '0;
            rdata_reg     <= '0;
            err_reg       <= 2'b00;
            err_cnt_reg   <= 8'd0;
            wait_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid_i && ready_reg) begin
                        ready_reg <= 1'b0;
                        write_reg <= bus.req_write_i;
                        addr_reg  <= bus.req_addr_i;
                        wdata_reg <= bus.req_wdata_i;
                        strb_reg  <= strb_next;
                        if (bus.req_wait_i && bus.busy_i) begin
                            state_reg <= WAIT_BUSY;
                        end else begin
                            state_reg    <= SETUP;
                            psel_reg     <= 1'b1;
                            wait_cnt_reg <= '0;
                        end
                    end
                end
                WAIT_BUSY: begin
                    if (!bus.busy_i) begin
                        state_reg    <= SETUP;
                        psel_reg     <= 1'b1;
                        wait_cnt_reg <= '0;
                    end
                end
                SETUP: begin
                    state_reg   <= ACCESS;
                    penable_reg <= 1'b1;
                end
                ACCESS: begin
                    // A completing pready wins over a timeout landing in the same cycle.
                    if (bus.pready_i) begin
                        state_reg     <= RESP;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rdata_reg     <= write_reg ? '0 : bus.prdata_i;
                        err_reg       <= {1'b0, bus.pslverr_i};
                    end else if (timeout_hit) begin
                        state_reg     <= RESP;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rdata_reg     <= '0;
                        err_reg       <= 2'b10;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        ready_reg     <= 1'b1;
                        if ((err_reg != 2'b00) && (err_cnt_reg != 8'hFF)) begin
                            err_cnt_reg <= err_cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Ready is held low for as long as reset is asserted.
    assign bus.req_ready_o = ready_reg & ~rst_i;
    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_rdata_o = rdata_reg;
    assign bus.rsp_err_o   = err_reg;
    assign bus.psel_o      = psel_reg;
    assign bus.penable_o   = penable_reg;
    assign bus.pwrite_o    = write_reg;
    assign bus.paddr_o     = addr_reg;
    assign bus.pwdata_o    = wdata_reg;
    assign bus.pstrb_o     = strb_reg;
    assign bus.err_cnt_o   = err_cnt_reg;
endmodule

// File: tb/tb_matmul_apb_master.sv
// Randomized scoreboard bench for matmul_apb_master: a driver pushes expected
// responses, a modelled APB slave serves transfers, a monitor pops and compares.
module tb_matmul_apb_master;
    localparam int TMO = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        write;
        logic [3:0]  strb;
        logic        slverr;
        int          waits;
        int          exp_acc;
    } cfg_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic clk;
    logic rst;
    logic busy_random, busy_force, busy_rnd;
    logic rr_random, rr_force, rr_rnd;

    cfg_t cfg_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_err_cnt = 0;

    matmul_apb_master_if #(.BUS_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    matmul_apb_master #(
        .BUS_WIDTH  (32),
        .ADDR_WIDTH (32),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb bus.busy_i      = busy_random ? busy_rnd : busy_force;
    always_comb bus.rsp_ready_i = rr_random ? rr_rnd : rr_force;

    initial begin
        busy_rnd = 1'b0;
        rr_rnd   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            busy_rnd = ($urandom_range(0, 3) == 0);
            rr_rnd   = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // APB slave model: serves transfers in request order from cfg_q.
    initial begin
        cfg_t cur;
        bit   in_xfer = 0;
        int   acc = 0;
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_xfer = 0;
                bus.pready_i = 1'b0;
                continue;
            end
            if (bus.psel_o && !bus.penable_o) begin
                if (cfg_q.size() == 0) begin
                    chk("apb_unexpected_setup", 1, 0);
                end else begin
                    cur = cfg_q.pop_front();
                    chk("apb_addr", bus.paddr_o, cur.addr);
                    chk("apb_write", bus.pwrite_o, cur.write);
                    chk("apb_wdata", bus.pwdata_o, cur.wdata);
                    chk("apb_strb", bus.pstrb_o, cur.strb);
                end
                in_xfer = 1;
                acc = 0;
                bus.pready_i = 1'b0;
            end else if (bus.psel_o && bus.penable_o && in_xfer) begin
                chk("apb_addr_stable", {bus.paddr_o, bus.pstrb_o}, {cur.addr, cur.strb});
                bus.pready_i  = (acc == cur.waits);
                bus.prdata_i  = bus.pready_i ? cur.prdata : $urandom;
                bus.pslverr_i = bus.pready_i ? cur.slverr : 1'($urandom_range(0, 1));
                acc++;
            end else begin
                if (in_xfer) chk("access_cycles", acc, cur.exp_acc);
                in_xfer = 0;
                bus.pready_i  = 1'b0;
                bus.pslverr_i = 1'($urandom_range(0, 1));
                bus.prdata_i  = $urandom;
            end
        end
    end

    // Response monitor: compares every response handshake with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    chk("rsp_err", bus.rsp_err_o, e.err);
                    chk("err_cnt", bus.err_cnt_o, model_err_cnt);
                    if (e.err != 2'b00 && model_err_cnt < 255) model_err_cnt++;
                end
            end
        end
    end

    task automatic do_req(input bit wr, input bit wt, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int waits, input logic [31:0] rdata, input bit slverr);
        cfg_t c;
        exp_t e;
        bit   got = 0;
        @(posedge clk);
        #1;
        c.addr = addr; c.write = wr; c.wdata = wdata; c.strb = wr ? strb : 4'h0;
        c.waits = waits; c.prdata = rdata; c.slverr = slverr;
        c.exp_acc = (waits >= TMO) ? TMO : waits + 1;
        if (waits >= TMO) begin
            e.rdata = '0;
            e.err   = 2'b10;
        end else begin
            e.rdata = wr ? 32'h0 : rdata;
            e.err   = {1'b0, slverr};
        end
        cfg_q.push_back(c);
        exp_q.push_back(e);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_wait_i  = wt;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        bus.req_strb_i  = strb;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("req_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'($urandom_range(0, 1));
        bus.req_wait_i  = 1'($urandom_range(0, 1));
        bus.req_addr_i  = $urandom;
        bus.req_wdata_i = $urandom;
        bus.req_strb_i  = 4'($urandom);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic cycles_to_rsp(input int start, output int n);
        n = start;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid_o) return;
        end
        n = -1;
    endtask

    initial begin
        int n;
        bit ok;
        rst = 1'b1;
        busy_random = 1'b0; busy_force = 1'b0;
        rr_random = 1'b0;   rr_force = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_wait_i = 1'b0;
        bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_strb_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_psel_penable", {bus.psel_o, bus.penable_o}, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_err_cnt", bus.err_cnt_o, 0);
        chk("rst_paddr", bus.paddr_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready_o, 1);

        // Minimum-latency write.
        do_req(1, 0, 32'h0, 32'h0000_0001, 4'hF, 0, 32'h1234_5678, 0);
        @(negedge clk);
        chk("t1_setup", {bus.psel_o, bus.penable_o}, 2'b10);
        @(negedge clk);
        chk("t1_access", {bus.psel_o, bus.penable_o}, 2'b11);
        @(negedge clk);
        chk("t1_rsp_at_n3", {bus.rsp_valid_o, bus.psel_o}, 2'b10);

        // Read with three wait states.
        do_req(0, 0, 32'h20, 32'hAAAA_5555, 4'hF, 3, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("t2_pstrb_read", {bus.psel_o, bus.pstrb_o}, {1'b1, 4'h0});
        cycles_to_rsp(1, n);
        chk("t2_latency", n, 6);

        // Slave error.
        do_req(0, 0, 32'h44, 32'h0, 4'h0, 0, 32'h0BAD_0BAD, 1);
        drain();
        chk("t3_err_cnt", bus.err_cnt_o, 1);

        // pready never arrives.
        do_req(0, 0, 32'h48, 32'h0, 4'h0, 100, 32'hFFFF_FFFF, 1);
        cycles_to_rsp(0, n);
        chk("t4_timeout_latency", n, TMO + 2);
        drain();
        chk("t4_err_cnt", bus.err_cnt_o, 2);

        // Hold-off on busy.
        busy_force = 1'b1;
        do_req(1, 1, 32'h80, 32'hCAFE_F00D, 4'h3, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_psel_held", bus.psel_o, 0);
        end
        @(posedge clk);
        #1 busy_force = 1'b0;
        @(negedge clk);
        chk("t5_still_waiting", bus.psel_o, 0);
        @(negedge clk);
        chk("t5_setup_after_busy", {bus.psel_o, bus.penable_o}, 2'b10);
        drain();

        // Reset in the middle of ACCESS.
        do_req(0, 0, 32'h90, 32'h0, 4'h0, 8, 32'h5555_AAAA, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_access", {bus.psel_o, bus.penable_o}, 2'b11);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_ready_low_in_reset", bus.req_ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        cfg_q.delete();
        model_err_cnt = 0;
        @(negedge clk);
        chk("t6_bus_idle", {bus.psel_o, bus.penable_o}, 0);
        chk("t6_no_rsp", bus.rsp_valid_o, 0);
        chk("t6_ready", bus.req_ready_o, 1);
        chk("t6_err_cnt_cleared", bus.err_cnt_o, 0);
        ok = 1;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid_o) ok = 0;
        end
        chk("t6_no_late_rsp", ok, 1);

        // Response back-pressure.
        rr_force = 1'b0;
        do_req(0, 0, 32'hA0, 32'h0, 4'h0, 1, 32'h1357_9BDF, 1);
        cycles_to_rsp(0, n);
        chk("t7_rsp_seen", n > 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t7_hold", {bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o, bus.req_ready_o},
                {1'b1, 32'h1357_9BDF, 2'b01, 1'b0});
        end
        @(posedge clk);
        #1 rr_force = 1'b1;
        drain();

        // Randomized traffic.
        busy_random = 1'b1;
        rr_random   = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int sel;
            int w;
            sel = $urandom_range(0, 9);
            w = (sel == 0) ? $urandom_range(TMO, TMO + 4) : (sel == 1) ? TMO - 1 : $urandom_range(0, 3);
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                   $urandom, 4'($urandom), w, $urandom, ($urandom_range(0, 3) == 0));
        end
        drain();
        chk("rand_err_cnt", bus.err_cnt_o, model_err_cnt);

        // Saturate the error counter.
        for (int i = 0; i < 260; i++) begin
            do_req(0, 0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0, 0, $urandom, 1);
        end
        drain();
        chk("sat_err_cnt", bus.err_cnt_o, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/matmul_apb_master.md
# matmul_apb_master

Upstream APB master stage for the matmul accelerator. It accepts single register/scratchpad access requests on a valid/ready request port, and drives each one as a standard two-phase APB transfer (SETUP, then ACCESS) onto the matmul slave port. It returns read data and error status on a valid/ready response port, and can optionally hold a request until the accelerator deasserts `busy`.

## Interface
Parameters:
- `BUS_WIDTH`, 32, APB data width; `pstrb` width is `BUS_WIDTH/8`.
- `ADDR_WIDTH`, 32, APB address width.
- `TIMEOUT_CYC`, 16, maximum ACCESS cycles without `pready`; 0 disables the timeout.

Ports:
- `clk_i`, in, 1, the single clock.
- `rst_i`, in, 1, reset; synchronous and active-high.
- `req_valid_i`, in, 1, request valid.
- `req_ready_o`, out, 1, request accepted when high together with `req_valid_i`.
- `req_write_i`, in, 1, 1 selects write, 0 selects read.
- `req_wait_i`, in, 1, hold the request until `busy_i` is 0.
- `req_addr_i`, in, `ADDR_WIDTH`, target address.
- `req_wdata_i`, in, `BUS_WIDTH`, write data.
- `req_strb_i`, in, `BUS_WIDTH/8`, write byte strobes.
- `rsp_valid_o`, out, 1, response valid.
- `rsp_ready_i`, in, 1, response consumed.
- `rsp_rdata_o`, out, `BUS_WIDTH`, read data; 0 for writes and timeouts.
- `rsp_err_o`, out, 2, bit 0 = `pslverr`, bit 1 = timeout.
- `psel_o`, `penable_o`, `pwrite_o`, out, 1 each, APB controls.
- `paddr_o`, out, `ADDR_WIDTH`; `pwdata_o`, out, `BUS_WIDTH`; `pstrb_o`, out, `BUS_WIDTH/8`.
- `pready_i`, `pslverr_i`, in, 1 each; `prdata_i`, in, `BUS_WIDTH`.
- `busy_i`, in, 1, matmul busy flag.
- `err_cnt_o`, out, 8, saturating count of responses with a nonzero `rsp_err_o`.

## Operation
- FSM states: IDLE, WAIT_BUSY, SETUP, ACCESS, RESP.
- **IDLE:** `req_ready_o`=1. On handshake, latch write, wait, address, wdata and strb.
  - `pstrb` is latched as 0 for reads.
  - Next state is WAIT_BUSY if `req_wait_i` && `busy_i`, else SETUP.
- **WAIT_BUSY:** `psel_o`=0. Go to SETUP in the cycle after `busy_i` is sampled 0. No timeout applies here.
- **SETUP:** `psel_o`=1, `penable_o`=0. Lasts exactly one cycle, then ACCESS.
- **ACCESS:** `psel_o`=1, `penable_o`=1.
  - If `pready_i`=1: latch `prdata_i` (reads only) and `pslverr_i` into `rsp_err_o[0]`, then go to RESP.
  - Otherwise increment the wait counter. If the counter reaches `TIMEOUT_CYC` (and `TIMEOUT_CYC`≠0): `rsp_err_o`=2'b10, rdata 0, go to RESP.
  - `pslverr_i` is ignored when `pready_i`=0.
- **RESP:** `rsp_valid_o`=1 and the response fields are held stable. On `rsp_ready_i`, go to IDLE.
- `paddr_o`, `pwrite_o`, `pwdata_o`, `pstrb_o` are driven from the latched registers and are stable throughout SETUP and ACCESS.
- `err_cnt_o` increments on each RESP handshake with `rsp_err_o`≠0 and saturates at 255.
- The wait counter clears on entry to SETUP.

## Timing
- Reset values: `req_ready_o`=0 during reset, 1 in the first cycle after reset. All other outputs reset to 0, and the FSM resets to IDLE.
- Minimum latency: handshake at edge N; SETUP in cycle N+1; ACCESS in cycle N+2 with `pready`; `rsp_valid_o` high in cycle N+3.
- With `rsp_ready_i` held at 1, the next request is accepted at N+4, giving a throughput of 1 transfer per 4 cycles.
- Each `pready` wait cycle adds 1 cycle of latency.
- A timeout occurs after exactly `TIMEOUT_CYC` ACCESS cycles. `psel_o`/`penable_o` drop in the following cycle.
- Reset asserted in any state returns the FSM to IDLE at the next edge.
  - `psel_o`/`penable_o`/`rsp_valid_o` go to 0.
  - The pending request is dropped and no response is issued.
  - `err_cnt_o` clears.
- `req_valid_i` outside IDLE is not accepted; upstream must hold it.
- A `busy_i` change during SETUP/ACCESS has no effect on the transfer.

## Test plan
- Write addr 0x0, data 0x0000_0001, strb 0xF, `pready` in the first ACCESS cycle:
  - `psel` high for 2 cycles, `penable` high in the 2nd.
  - `rsp_valid` at N+3 with `rsp_err`=0 and rdata 0.
- Read addr 0x20 with `prdata`=0xDEAD_BEEF after 3 wait cycles:
  - `pstrb_o`=0; `rsp_rdata_o`=0xDEAD_BEEF at N+6.
- Read with `pslverr`=1 and `pready`=1 → `rsp_err_o`=2'b01, `err_cnt_o`=1.
- `pready` never asserted, `TIMEOUT_CYC`=16 → exactly 16 ACCESS cycles, then `rsp_err_o`=2'b10, `err_cnt_o` increments.
- `req_wait_i`=1 with `busy_i` high for 10 cycles:
  - `psel_o` stays 0 throughout.
  - SETUP follows 1 cycle after `busy_i` falls.
- `rst_i` pulsed during ACCESS → `psel_o`/`penable_o` are 0 the next cycle, no `rsp_valid`, `req_ready_o`=1 after reset.
- 255+ errors → `err_cnt_o` saturates at 255.
- `rsp_ready_i` held 0 for 5 cycles → the response stays stable and `req_ready_o` stays 0.
